// File: rtl/serial_negator_pkg.sv
// Shared types and defaults for the bit-serial negator: the transform-mode
// encoding, the per-lane scan/flip state, and the default word and lane counts.
package serial_negator_pkg;

   localparam int DEFAULT_WIDTH    = 8;
   localparam int DEFAULT_CHANNELS = 4;

   // Transform applied to a whole word; the reserved code behaves as PASS.
   typedef enum logic [1:0] {
      PASS = 2'b00,
      NEG  = 2'b01,
      ONES = 2'b10,
      RSVD = 2'b11
   } mode_e;

   // SCAN: no 1 seen yet in this word. FLIP: a 1 has gone by, so invert the rest.
   typedef enum logic {
      SCAN = 1'b0,
      FLIP = 1'b1
   } lane_state_e;

endpackage

// File: rtl/serial_negator_lane.sv
// One serial lane: scan/flip FSM for two's-complement negation, the per-bit
// transform, and detection of negating the most-negative value.
module serial_negator_lane
   import serial_negator_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  accept,
   input  logic  word_start,
   input  logic  is_last,
   input  mode_e mode,
   input  logic  bit_in,
   output logic  y,
   output logic  ovf
);

   lane_state_e state_q, state_d, cur_state;
   logic        y_q, y_d;
   logic        ovf_q, ovf_d;

   // Lane state, output bit and overflow flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCAN;
         y_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next state, transformed bit and overflow; bit 0 always starts from SCAN.
   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      ovf_d     = 1'b0;
      cur_state = word_start ? SCAN : state_q;
      if (accept) begin
         case (mode)
            NEG:     y_d = (cur_state == FLIP) ? ~bit_in : bit_in;
            ONES:    y_d = ~bit_in;
            default: y_d = bit_in;
         endcase
         state_d = ((cur_state == FLIP) || bit_in) ? FLIP : SCAN;
         ovf_d   = is_last && (mode == NEG) && (cur_state == SCAN) && bit_in;
      end else if (clr) begin
         state_d = SCAN;
      end
   end

   assign y   = y_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/serial_negator.sv
// Multi-lane bit-serial negator: shared bit counter and per-word mode latch,
// with one transform lane per channel and one cycle of latency.
module serial_negator
   import serial_negator_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int CHANNELS = DEFAULT_CHANNELS
) (
   input  logic                t_clk,
   input  logic                r_n,
   input  logic                clr,
   input  logic                in_valid,
   input  logic [CHANNELS-1:0] i,
   input  logic [1:0]          mode,
   output logic [CHANNELS-1:0] y,
   output logic                out_valid,
   output logic                out_first,
   output logic                out_last,
   output logic [CHANNELS-1:0] ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   // Reject unsupported word or lane counts at elaboration.
   generate
      if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
         $error("serial_negator: WIDTH must be in 2..64");
      end
      if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
         $error("serial_negator: CHANNELS must be in 1..32");
      end
   endgenerate

   logic [CW-1:0] cnt_q, cnt_d, bit_idx;
   mode_e         mode_q, mode_d, mode_eff;
   logic          word_start, is_last;
   logic          out_valid_q, out_valid_d;
   logic          out_first_q, out_first_d;
   logic          out_last_q, out_last_d;

   // Bit counter, latched word mode and framing output registers.
   always_ff @(posedge t_clk or negedge r_n) begin
      if (!r_n) begin
         cnt_q       <= '0;
         mode_q      <= PASS;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
      end
   end

   // A clr turns the current bit into bit 0 of a fresh word, taking the mode pins directly.
   always_comb begin
      bit_idx     = clr ? '0 : cnt_q;
      word_start  = (bit_idx == '0);
      is_last     = (bit_idx == LAST_IDX);
      mode_eff    = word_start ? mode_e'(mode) : mode_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      out_valid_d = in_valid;
      out_first_d = in_valid && word_start;
      out_last_d  = in_valid && is_last;
      if (in_valid) begin
         cnt_d = is_last ? '0 : bit_idx + CW'(1);
         if (word_start) begin
            mode_d = mode_e'(mode);
         end
      end else if (clr) begin
         cnt_d = '0;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      serial_negator_lane u_lane (
         .clk        (t_clk),
         .rst_n      (r_n),
         .clr        (clr),
         .accept     (in_valid),
         .word_start (word_start),
         .is_last    (is_last),
         .mode       (mode_eff),
         .bit_in     (i[k]),
         .y          (y[k]),
         .ovf        (ovf[k])
      );
   end

   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;

endmodule
